axi_stream_mux_n: RTL and testbench

- Parametrised N-input AXI-Stream multiplexer; next generation of the fixed 3-input mux.
- Adds a full-throughput registered output with a skid buffer, correct backpressure, and packet-aware switching that never splits a packet across sources.
- Sits between multiple stream producers (ADC channels, processing cores) and a single consumer (DMA, scope buffer).

---
 rtl/axi_stream_mux_n_if.sv | 17 +
 rtl/axi_stream_mux_n.sv | 129 ++++++++++++
 tb/tb_axi_stream_mux_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_mux_n_if.sv
// AXI-Stream link carrying data, dest, user and tlast with a valid/ready handshake.
// Master drives payload and valid; slave drives ready.
interface axi_stream_mux_n_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tdest, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tdest, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axi_stream_mux_n.sv
// N-input AXI-Stream mux with registered output and one skid beat; 1-cycle latency, 1 beat/cycle.
// Backpressure: input ready comes only from flops and drops once the skid register holds a beat.
module axi_stream_mux_n #(
    parameter int N_INPUTS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 8,
    parameter bit PACKET_LOCK = 1'b1
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic [$clog2(N_INPUTS)-1:0] address_i,
    axi_stream_mux_n_if.slave           stream_in [N_INPUTS],
    axi_stream_mux_n_if.master          stream_out,
    output logic [$clog2(N_INPUTS)-1:0] selected_o,
    output logic                        busy_o
);
    localparam int SEL_W = $clog2(N_INPUTS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } beat_t;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             in_packet_q, in_packet_d;
    logic             rdy_en_q;
    logic             or_vld_q, or_vld_d;
    beat_t            or_q, or_d;
    logic             sk_vld_q, sk_vld_d;
    beat_t            sk_q, sk_d;

    logic [N_INPUTS-1:0] in_vld;
    beat_t               in_beat [N_INPUTS];
    logic                sel_vld;
    beat_t               sel_beat;
    logic                accept;
    logic                addr_ok;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_in
        assign in_vld[g]  = stream_in[g].tvalid;
        assign in_beat[g] = '{dat:  stream_in[g].tdata,
                              dest: stream_in[g].tdest,
                              user: stream_in[g].tuser,
                              last: stream_in[g].tlast};
        // rdy_en_q keeps every ready low until the first edge after reset release
        assign stream_in[g].tready = rdy_en_q && !sk_vld_q && (sel_q == SEL_W'(g));
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_beat = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_vld  = in_vld[i];
                sel_beat = in_beat[i];
            end
        end
    end

    assign accept  = sel_vld && rdy_en_q && !sk_vld_q;
    assign addr_ok = int'(address_i) < N_INPUTS;

    always_comb begin
        sel_d       = sel_q;
        in_packet_d = in_packet_q;
        or_vld_d    = or_vld_q;
        or_d        = or_q;
        sk_vld_d    = sk_vld_q;
        sk_d        = sk_q;

        // An accept only happens with the skid empty, so it never races a skid drain
        if (accept) begin
            in_packet_d = !sel_beat.last;
            if (!or_vld_q || stream_out.tready) begin
                or_d     = sel_beat;
                or_vld_d = 1'b1;
            end else begin
                sk_d     = sel_beat;
                sk_vld_d = 1'b1;
            end
        end else if (or_vld_q && stream_out.tready) begin
            if (sk_vld_q) begin
                or_d     = sk_q;
                sk_vld_d = 1'b0;
            end else begin
                or_vld_d = 1'b0;
            end
        end

        if (addr_ok) begin
            if (!PACKET_LOCK) begin
                sel_d = address_i;
            end else if (!in_packet_q && !(accept && !sel_beat.last)) begin
                sel_d = address_i;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sel_q       <= '0;
            in_packet_q <= 1'b0;
            rdy_en_q    <= 1'b0;
            or_vld_q    <= 1'b0;
            or_q        <= '0;
            sk_vld_q    <= 1'b0;
            sk_q        <= '0;
        end else begin
            sel_q       <= sel_d;
            in_packet_q <= in_packet_d;
            rdy_en_q    <= 1'b1;
            or_vld_q    <= or_vld_d;
            or_q        <= or_d;
            sk_vld_q    <= sk_vld_d;
            sk_q        <= sk_d;
        end
    end

    assign stream_out.tvalid = or_vld_q;
    assign stream_out.tdata  = or_q.dat;
    assign stream_out.tdest  = or_q.dest;
    assign stream_out.tuser  = or_q.user;
    assign stream_out.tlast  = or_q.last;
    assign selected_o        = sel_q;
    assign busy_o            = in_packet_q;
endmodule

// File: tb/tb_axi_stream_mux_n.sv
// Directed bench for axi_stream_mux_n: one packet-locked instance and one free-switching instance.
// Five inputs are used so the 3-bit address can express out-of-range indices.
module tb_axi_stream_mux_n;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int EW = 8;
    localparam int UW = 8;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n;
    logic [SW-1:0] a_addr, b_addr;
    logic          a_vld  [N];
    logic [DW-1:0] a_dat  [N];
    logic [EW-1:0] a_dest [N];
    logic [UW-1:0] a_user [N];
    logic          a_last [N];
    logic [N-1:0]  a_rdy;
    logic          b_vld  [N];
    logic [DW-1:0] b_dat  [N];
    logic [EW-1:0] b_dest [N];
    logic [UW-1:0] b_user [N];
    logic          b_last [N];
    logic [N-1:0]  b_rdy;
    logic [SW-1:0] a_sel, b_sel;
    logic          a_busy, b_busy;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_stream_mux_n_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) a_in [N] ();
    axi_stream_mux_n_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) a_out ();
    axi_stream_mux_n_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) b_in [N] ();
    axi_stream_mux_n_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) b_out ();

    for (genvar g = 0; g < N; g++) begin : g_conn
        assign a_in[g].tvalid = a_vld[g];
        assign a_in[g].tdata  = a_dat[g];
        assign a_in[g].tdest  = a_dest[g];
        assign a_in[g].tuser  = a_user[g];
        assign a_in[g].tlast  = a_last[g];
        assign a_rdy[g]       = a_in[g].tready;
        assign b_in[g].tvalid = b_vld[g];
        assign b_in[g].tdata  = b_dat[g];
        assign b_in[g].tdest  = b_dest[g];
        assign b_in[g].tuser  = b_user[g];
        assign b_in[g].tlast  = b_last[g];
        assign b_rdy[g]       = b_in[g].tready;
    end

    axi_stream_mux_n #(.N_INPUTS(N), .DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW),
                       .PACKET_LOCK(1'b1)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .address_i(a_addr),
        .stream_in(a_in), .stream_out(a_out), .selected_o(a_sel), .busy_o(a_busy));

    axi_stream_mux_n #(.N_INPUTS(N), .DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW),
                       .PACKET_LOCK(1'b0)) dut_free (
        .clock_i(clk), .reset_n_i(rst_n), .address_i(b_addr),
        .stream_in(b_in), .stream_out(b_out), .selected_o(b_sel), .busy_o(b_busy));

    task automatic init_inputs();
        for (int i = 0; i < N; i++) begin
            a_vld[i] = 1'b0; a_dat[i] = '0; a_dest[i] = '0; a_user[i] = '0; a_last[i] = 1'b0;
            b_vld[i] = 1'b0; b_dat[i] = '0; b_dest[i] = '0; b_user[i] = '0; b_last[i] = 1'b0;
        end
        a_addr = '0; b_addr = '0;
        a_out.tready = 1'b0; b_out.tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        init_inputs();
        #2 rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (a_rdy !== '0 || b_rdy !== '0) begin errors++; $display("FAIL rst_ready c%0d: got %b/%b want 0", c, a_rdy, b_rdy); end
            checks++; if (a_out.tvalid !== 1'b0 || a_out.tdata !== '0 || a_out.tlast !== 1'b0) begin errors++; $display("FAIL rst_out c%0d: got vld=%b dat=%h last=%b want 0", c, a_out.tvalid, a_out.tdata, a_out.tlast); end
        end
        checks++; if (a_sel !== '0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_state: got sel=%0d busy=%b want 0/0", a_sel, a_busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_rdy !== 5'b00001) begin errors++; $display("FAIL rst_release_ready: got %b want 00001", a_rdy); end
        checks++; if (b_rdy !== 5'b00001) begin errors++; $display("FAIL rst_release_ready_free: got %b want 00001", b_rdy); end
    endtask

    task automatic test_single_beat();
        a_addr = 3'd2; a_out.tready = 1'b1;
        @(negedge clk);
        checks++; if (a_sel !== 3'd2 || a_rdy !== 5'b00100) begin errors++; $display("FAIL single_sel: got sel=%0d rdy=%b want 2/00100", a_sel, a_rdy); end
        a_vld[2] = 1'b1; a_dat[2] = 32'hA5A5; a_dest[2] = 8'd3; a_user[2] = 8'd1; a_last[2] = 1'b1;
        @(negedge clk);
        a_vld[2] = 1'b0;
        checks++; if (a_out.tvalid !== 1'b1 || a_out.tdata !== 32'hA5A5) begin errors++; $display("FAIL single_data: got vld=%b dat=%h want 1/a5a5", a_out.tvalid, a_out.tdata); end
        checks++; if (a_out.tdest !== 8'd3 || a_out.tuser !== 8'd1 || a_out.tlast !== 1'b1) begin errors++; $display("FAIL single_fields: got dest=%0d user=%0d last=%b want 3/1/1", a_out.tdest, a_out.tuser, a_out.tlast); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", a_busy); end
        @(negedge clk);
        checks++; if (a_out.tvalid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_drain: got vld=%b busy=%b want 0/0", a_out.tvalid, a_busy); end
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        int  rx = 0;
        bit  pres = 1'b0;
        bit  rdy_prev = 1'b0;
        a_addr = 3'd1;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (pres && rdy_prev) idx++;
            a_out.tready = !(c >= 3 && c <= 7);
            if (a_out.tvalid && a_out.tready) begin
                checks++; if (a_out.tdata !== DW'(rx)) begin errors++; $display("FAIL stall_order: got %0d want %0d", a_out.tdata, rx); end
                rx++;
            end
            if (idx < 10) begin
                a_vld[1] = 1'b1; a_dat[1] = DW'(idx); a_last[1] = (idx == 9); pres = 1'b1;
            end else begin
                a_vld[1] = 1'b0; pres = 1'b0;
            end
            rdy_prev = a_rdy[1];
            if (c == 7) begin
                checks++; if (a_rdy[1] !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", a_rdy[1]); end
                checks++; if (idx - rx != 2) begin errors++; $display("FAIL stall_buffered: got %0d want 2", idx - rx); end
            end
            @(negedge clk);
        end
        checks++; if (rx != 10) begin errors++; $display("FAIL stall_count: got %0d want 10", rx); end
        checks++; if (a_out.tvalid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL stall_end: got vld=%b busy=%b want 0/0", a_out.tvalid, a_busy); end
    endtask

    task automatic test_packet_lock();
        a_addr = 3'd0; a_out.tready = 1'b1; a_vld[1] = 1'b0;
        @(negedge clk);
        checks++; if (a_sel !== 3'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL lock_start: got sel=%0d busy=%b want 0/0", a_sel, a_busy); end
        a_vld[0] = 1'b1; a_dat[0] = 32'h10; a_last[0] = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b1 || a_out.tdata !== 32'h10) begin errors++; $display("FAIL lock_b1: got busy=%b dat=%h want 1/10", a_busy, a_out.tdata); end
        a_dat[0] = 32'h11;
        @(negedge clk);
        checks++; if (a_busy !== 1'b1 || a_out.tdata !== 32'h11) begin errors++; $display("FAIL lock_b2: got busy=%b dat=%h want 1/11", a_busy, a_out.tdata); end
        a_addr = 3'd3; a_dat[0] = 32'h12;
        a_vld[3] = 1'b1; a_dat[3] = 32'hEE; a_last[3] = 1'b1;
        @(negedge clk);
        checks++; if (a_busy !== 1'b1 || a_sel !== 3'd0 || a_out.tdata !== 32'h12) begin errors++; $display("FAIL lock_b3: got busy=%b sel=%0d dat=%h want 1/0/12", a_busy, a_sel, a_out.tdata); end
        checks++; if (a_rdy !== 5'b00001) begin errors++; $display("FAIL lock_rdy: got %b want 00001", a_rdy); end
        a_dat[0] = 32'h13; a_last[0] = 1'b1;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_sel !== 3'd0 || a_out.tdata !== 32'h13 || a_out.tlast !== 1'b1) begin errors++; $display("FAIL lock_b4: got busy=%b sel=%0d dat=%h last=%b want 0/0/13/1", a_busy, a_sel, a_out.tdata, a_out.tlast); end
        a_vld[0] = 1'b0;
        @(negedge clk);
        checks++; if (a_sel !== 3'd3 || a_rdy !== 5'b01000) begin errors++; $display("FAIL lock_switch: got sel=%0d rdy=%b want 3/01000", a_sel, a_rdy); end
        @(negedge clk);
        checks++; if (a_out.tvalid !== 1'b1 || a_out.tdata !== 32'hEE || a_out.tlast !== 1'b1) begin errors++; $display("FAIL lock_newsrc: got vld=%b dat=%h want 1/ee", a_out.tvalid, a_out.tdata); end
        a_vld[3] = 1'b0;
    endtask

    task automatic test_out_of_range();
        b_addr = 3'd1; b_out.tready = 1'b1;
        @(negedge clk);
        checks++; if (b_sel !== 3'd1) begin errors++; $display("FAIL oor_start: got sel=%0d want 1", b_sel); end
        for (int k = 0; k < 10; k++) begin
            b_addr = SW'(5 + k % 3);
            b_vld[1] = 1'b1; b_dat[1] = 32'h100 + DW'(k); b_last[1] = 1'b0;
            @(negedge clk);
            checks++; if (b_sel !== 3'd1 || b_rdy !== 5'b00010) begin errors++; $display("FAIL oor_hold k%0d: got sel=%0d rdy=%b want 1/00010", k, b_sel, b_rdy); end
            checks++; if (b_out.tvalid !== 1'b1 || b_out.tdata !== 32'h100 + DW'(k)) begin errors++; $display("FAIL oor_data k%0d: got vld=%b dat=%h want 1/%h", k, b_out.tvalid, b_out.tdata, 32'h100 + k); end
        end
        b_vld[1] = 1'b0; b_addr = 3'd2;
        @(negedge clk);
        checks++; if (b_sel !== 3'd2 || b_rdy !== 5'b00100) begin errors++; $display("FAIL oor_switch: got sel=%0d rdy=%b want 2/00100", b_sel, b_rdy); end
    endtask

    task automatic test_reset_mid_packet();
        a_addr = 3'd0; a_out.tready = 1'b0;
        @(negedge clk);
        a_vld[0] = 1'b1; a_dat[0] = 32'h20; a_last[0] = 1'b0;
        @(negedge clk);
        a_dat[0] = 32'h21;
        @(negedge clk);
        checks++; if (a_rdy !== '0 || a_busy !== 1'b1 || a_out.tvalid !== 1'b1 || a_out.tdata !== 32'h20) begin errors++; $display("FAIL mid_full: got rdy=%b busy=%b vld=%b dat=%h want 0/1/1/20", a_rdy, a_busy, a_out.tvalid, a_out.tdata); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_out.tvalid !== 1'b0 || a_out.tdata !== '0 || a_out.tlast !== 1'b0) begin errors++; $display("FAIL mid_async_out: got vld=%b dat=%h want 0/0", a_out.tvalid, a_out.tdata); end
        checks++; if (a_busy !== 1'b0 || a_sel !== '0 || a_rdy !== '0) begin errors++; $display("FAIL mid_async_state: got busy=%b sel=%0d rdy=%b want 0/0/0", a_busy, a_sel, a_rdy); end
        @(negedge clk);
        a_vld[0] = 1'b0; a_out.tready = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_rdy !== 5'b00001 || a_out.tvalid !== 1'b0) begin errors++; $display("FAIL mid_release: got rdy=%b vld=%b want 00001/0", a_rdy, a_out.tvalid); end
        a_vld[0] = 1'b1; a_dat[0] = 32'h55; a_last[0] = 1'b0;
        @(negedge clk);
        checks++; if (a_out.tdata !== 32'h55 || a_busy !== 1'b1) begin errors++; $display("FAIL mid_new1: got dat=%h busy=%b want 55/1", a_out.tdata, a_busy); end
        a_dat[0] = 32'h56; a_last[0] = 1'b1;
        @(negedge clk);
        a_vld[0] = 1'b0;
        checks++; if (a_out.tdata !== 32'h56 || a_out.tlast !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_new2: got dat=%h last=%b busy=%b want 56/1/0", a_out.tdata, a_out.tlast, a_busy); end
        @(negedge clk);
        checks++; if (a_out.tvalid !== 1'b0) begin errors++; $display("FAIL mid_drain: got vld=%b want 0", a_out.tvalid); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_packet_lock();
        test_out_of_range();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
